// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_hazard_unit_pkg: shared select codes and stage-slot type for the forwarding/hazard unit
package fwd_hazard_unit_pkg;
   localparam int SLOT_RD_W = 5;
   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b01;
   localparam logic [1:0] FWD_MEMWB   = 2'b10;
   typedef struct packed {
      logic [SLOT_RD_W-1:0] rd;
      logic                 reg_write;
      logic                 mem_read;
   } slot_t;
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: decode-stage fields in, operand selects / stall / stall count out
// master drives enable, flush and id_* fields; slave (the unit) drives selects, stall, stall_count
interface fwd_hazard_unit_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic                  enable;
   logic                  flush;
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_uses_rs1;
   logic                  id_uses_rs2;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_reg_write;
   logic                  id_mem_read;
   logic [1:0]            fwd_a_sel;
   logic [1:0]            fwd_b_sel;
   logic                  stall;
   logic [CNT_W-1:0]      stall_count;
   modport master (
      output enable, flush, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             id_rd, id_reg_write, id_mem_read,
      input  fwd_a_sel, fwd_b_sel, stall, stall_count
   );
   modport slave (
      input  enable, flush, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             id_rd, id_reg_write, id_mem_read,
      output fwd_a_sel, fwd_b_sel, stall, stall_count
   );
endinterface

// File: rtl/fwd_hazard_unit_fwd_select.sv
// fwd_select: per-operand forwarding comparator (EX source vs MEM/WB slots -> mux select)
// rs_i: EX source register; mem_i/wb_i: MEM and WB slots; sel_o: 2-bit operand mux select
module fwd_select
   import fwd_hazard_unit_pkg::*;
(
   input  logic [SLOT_RD_W-1:0] rs_i,
   input  slot_t                mem_i,
   input  slot_t                wb_i,
   output logic [1:0]           sel_o
);
   always_comb begin
      sel_o = (mem_i.reg_write && mem_i.rd != '0 && mem_i.rd == rs_i) ? FWD_EXMEM :
              (wb_i.reg_write && wb_i.rd != '0 && wb_i.rd == rs_i)    ? FWD_MEMWB : FWD_REGFILE;
   end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding selects, load-use stall and saturating stall counter
// clk/arst_n: clock and async active-low reset; bus (slave): decode fields in, selects/stall/count out
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int REG_ADDR_W = SLOT_RD_W,
   parameter int CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     arst_n,
   fwd_hazard_unit_if.slave         bus
);
   slot_t                 ex_q, ex_d, mem_q, wb_q;
   logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  hit, take;
   logic [1:0]            sel_a, sel_b;
   always_comb begin
      hit      = bus.id_valid && ex_q.mem_read && ex_q.rd != '0 &&
                 ((bus.id_uses_rs1 && bus.id_rs1 == ex_q.rd) ||
                  (bus.id_uses_rs2 && bus.id_rs2 == ex_q.rd));
      take     = bus.id_valid && !hit && !bus.flush;
      ex_d     = take ? slot_t'{rd: bus.id_rd, reg_write: bus.id_reg_write, mem_read: bus.id_mem_read} : slot_t'('0);
      // unused sources load as x0 so they can never match a forwarding slot
      ex_rs1_d = (take && bus.id_uses_rs1) ? bus.id_rs1 : '0;
      ex_rs2_d = (take && bus.id_uses_rs2) ? bus.id_rs2 : '0;
      cnt_d    = (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ex_q     <= '0;
         mem_q    <= '0;
         wb_q     <= '0;
         ex_rs1_q <= '0;
         ex_rs2_q <= '0;
         cnt_q    <= '0;
      end else if (bus.enable) begin
         ex_q     <= ex_d;
         mem_q    <= ex_q;
         wb_q     <= mem_q;
         ex_rs1_q <= ex_rs1_d;
         ex_rs2_q <= ex_rs2_d;
         cnt_q    <= cnt_d;
      end
   end
   fwd_select u_sel_a (.rs_i(ex_rs1_q), .mem_i(mem_q), .wb_i(wb_q), .sel_o(sel_a));
   fwd_select u_sel_b (.rs_i(ex_rs2_q), .mem_i(mem_q), .wb_i(wb_q), .sel_o(sel_b));
   assign bus.fwd_a_sel   = sel_a;
   assign bus.fwd_b_sel   = sel_b;
   assign bus.stall       = hit;
   assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed plus random checks of fwd_hazard_unit against an instruction-history model
module tb_fwd_hazard_unit;
   localparam int CW = 2;
   typedef struct {
      logic [4:0] rs1, rs2, rd;
      bit         u1, u2, rw, mr;
   } ins_t;
   logic clk = 0;
   logic arst_n = 1;
   int   n_chk = 0;
   int   n_pass = 0;
   int   mcnt = 0;
   ins_t hist[$];
   fwd_hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(CW)) bus ();
   fwd_hazard_unit #(.REG_ADDR_W(5), .CNT_W(CW)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
   endtask
   // newest older instruction (1 = one ahead of EX, 2 = two ahead) that writes rs supplies it
   function automatic logic [1:0] want_sel(bit u, logic [4:0] rs);
      if (!u || rs == 0) return 2'd0;
      for (int k = 1; k <= 2; k++)
         if (hist[k].rw && hist[k].rd == rs) return 2'(k);
      return 2'd0;
   endfunction
   function automatic bit want_stall();
      return bus.id_valid && hist[0].mr && hist[0].rd != 0 &&
             ((bus.id_uses_rs1 && bus.id_rs1 == hist[0].rd) || (bus.id_uses_rs2 && bus.id_rs2 == hist[0].rd));
   endfunction
   task automatic model_reset();
      ins_t b = '{default: 0};
      hist = {b, b, b};
      mcnt = 0;
   endtask
   task automatic drive(input bit en, fl, v, input logic [4:0] r1, r2, input bit u1, u2,
                        input logic [4:0] rd, input bit rw, mr);
      bus.enable = en; bus.flush = fl; bus.id_valid = v;
      bus.id_rs1 = r1; bus.id_rs2 = r2; bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2;
      bus.id_rd = rd; bus.id_reg_write = rw; bus.id_mem_read = mr;
      #1;
      check("fwd_a", bus.fwd_a_sel, want_sel(hist[0].u1, hist[0].rs1));
      check("fwd_b", bus.fwd_b_sel, want_sel(hist[0].u2, hist[0].rs2));
      check("stall", bus.stall, want_stall());
      check("count", bus.stall_count, mcnt);
   endtask
   task automatic tick();
      ins_t n = '{default: 0};
      bit   st = want_stall();
      @(posedge clk);
      if (bus.enable) begin
         if (bus.id_valid && !st && !bus.flush)
            n = '{rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd, u1: bus.id_uses_rs1,
                  u2: bus.id_uses_rs2, rw: bus.id_reg_write, mr: bus.id_mem_read};
         hist.push_front(n);
         void'(hist.pop_back());
         if (st && mcnt < (1 << CW) - 1) mcnt++;
      end
      @(negedge clk);
   endtask
   task automatic nop();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      bus.enable = 0; bus.flush = 0; bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
      bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.id_rd = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
      model_reset();
      #2 arst_n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_a", bus.fwd_a_sel, 0);
         check("rst_b", bus.fwd_b_sel, 0);
         check("rst_stall", bus.stall, 0);
         check("rst_count", bus.stall_count, 0);
      end
      arst_n = 1;
      for (int i = 0; i < 3; i++) begin nop(); tick(); end
      // add x5, then sub reading x5/x6, then a reader of x5
      drive(1, 0, 1, 0, 0, 0, 0, 5, 1, 0); tick();
      drive(1, 0, 1, 5, 6, 1, 1, 9, 1, 0); tick();
      drive(1, 0, 1, 0, 5, 0, 1, 12, 1, 0);
      check("t2_a_exmem", bus.fwd_a_sel, 1);
      check("t2_b_rf", bus.fwd_b_sel, 0);
      tick();
      nop();
      check("t2_b_memwb", bus.fwd_b_sel, 2);
      tick();
      // back-to-back writers of x3, then a reader of x3
      drive(1, 0, 1, 0, 0, 0, 0, 3, 1, 0); tick();
      drive(1, 0, 1, 0, 0, 0, 0, 3, 1, 0); tick();
      drive(1, 0, 1, 0, 3, 0, 1, 0, 0, 0); tick();
      nop();
      check("t3_b_prio", bus.fwd_b_sel, 1);
      tick();
      // lw x7, then add reading x7
      drive(1, 0, 1, 0, 0, 0, 0, 7, 1, 1); tick();
      drive(1, 0, 1, 7, 0, 1, 0, 11, 1, 0);
      check("t4_stall", bus.stall, 1);
      check("t4_cnt0", bus.stall_count, 0);
      tick();
      drive(1, 0, 1, 7, 0, 1, 0, 11, 1, 0);
      check("t4_nostall", bus.stall, 0);
      tick();
      nop();
      check("t4_a_memwb", bus.fwd_a_sel, 2);
      check("t4_cnt1", bus.stall_count, 1);
      tick();
      // x0 is never forwarded and never stalls
      drive(1, 0, 1, 0, 0, 0, 0, 0, 1, 0); tick();
      drive(1, 0, 1, 0, 0, 1, 0, 4, 1, 0); tick();
      nop();
      check("t5_a_x0", bus.fwd_a_sel, 0);
      tick();
      drive(1, 0, 1, 0, 0, 0, 0, 0, 1, 1); tick();
      drive(1, 0, 1, 0, 0, 1, 1, 4, 1, 0);
      check("t5_stall_x0", bus.stall, 0);
      tick();
      // flush with a load-use stall, then freeze for two cycles
      drive(1, 0, 1, 0, 0, 0, 0, 8, 1, 1); tick();
      drive(1, 1, 1, 8, 0, 1, 0, 13, 1, 0);
      check("t6_stall", bus.stall, 1);
      tick();
      drive(0, 0, 1, 8, 0, 1, 0, 13, 1, 1); tick();
      drive(0, 0, 1, 1, 2, 1, 1, 14, 1, 0); tick();
      nop();
      check("t6_freeze_cnt", bus.stall_count, 2);
      check("t6_bubble_a", bus.fwd_a_sel, 0);
      check("t6_bubble_stall", bus.stall, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 1, 0, 0, 0, 0, 9, 1, 1); tick();
         drive(1, 0, 1, 0, 9, 0, 1, 15, 1, 0); tick();
         drive(1, 0, 1, 0, 9, 0, 1, 15, 1, 0); tick();
      end
      nop();
      check("t6_saturate", bus.stall_count, 3);
      tick();
      for (int i = 0; i < 400; i++) begin
         bit mr = ($urandom % 3) == 0;
         drive(($urandom % 8) != 0, ($urandom % 10) == 0, ($urandom % 5) != 0,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
               5'($urandom_range(0, 7)), mr | 1'($urandom), mr);
         tick();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
